regfile_wport_arbiter: RTL and testbench

//  Shares the register file's single write port between NREQ writeback sources
//  (pipeline WB, multi-cycle mul/div, load-return unit).

---
 rtl/regfile_wport_arbiter_pkg.sv | 21 ++
 rtl/regfile_wport_arbiter_fifo.sv | 41 ++++
 rtl/regfile_wport_arbiter.sv | 135 +++++++++++++
 tb/tb_regfile_wport_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wport_arbiter_pkg.sv
// Shared constants and the queued-write record for the register-file write-port arbiter.
package regfile_wport_arbiter_pkg;

  localparam int REG_ADDR_W   = 5;
  localparam int REG_W        = 32;
  localparam int REG_NUM      = 32;
  localparam int REG_NUM_LOG2 = 5;
  localparam int ARB_REQ_MAX  = 4;

  localparam logic [REG_W-1:0] ZERO_WORD    = '0;
  localparam logic             WRITE_ENABLE = 1'b1;
  localparam logic             RST_ENABLE   = 1'b1;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] waddr;
    logic [REG_W-1:0]      wdata;
  } wr_entry_t;

  localparam int ENTRY_W = $bits(wr_entry_t);

endpackage

// File: rtl/regfile_wport_arbiter_fifo.sv
// Per-requester synchronous FIFO; pointers carry one extra wrap bit so full/empty
// are told apart without a separate counter.
module regfile_arb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr, rptr;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= din;
  end

  assign head  = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Round-robin arbiter sharing the register-file write port between NREQ FIFO-buffered
// sources. Define REGFILE_ARB_SCOREBOARD_EN to add the per-register pending[] scoreboard.
module regfile_wport_arbiter
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*REG_ADDR_W-1:0] req_waddr,
  input  logic [NREQ*REG_W-1:0]      req_wdata,
  output logic                       rf_we,
  output logic [REG_ADDR_W-1:0]      rf_waddr,
  output logic [REG_W-1:0]           rf_wdata,
  output logic                       idle
`ifdef REGFILE_ARB_SCOREBOARD_EN
  , output logic [REG_NUM-1:0]       pending
`endif
);

  localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] push, pop, full, empty;
  wr_entry_t       head [NREQ];
  logic [RRW-1:0]  rr, gidx;
  logic            grant;

  // First non-empty FIFO at or after ptr, wrapping modulo NREQ.
  function automatic logic [RRW-1:0] rr_pick(input logic [NREQ-1:0] ne,
                                             input logic [RRW-1:0]  ptr);
    logic        found;
    int unsigned j;
    rr_pick = ptr;
    found   = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = (32'(ptr) + k) % NREQ;
      if (!found && ne[RRW'(j)]) begin
        rr_pick = RRW'(j);
        found   = 1'b1;
      end
    end
  endfunction

  always_comb begin
    grant = |(~empty);
    gidx  = rr_pick(~empty, rr);
  end

  // Ready ignores same-cycle pop, so a full FIFO stays closed even while draining.
  always_comb begin
    req_ready = '0;
    push      = '0;
    pop       = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_ready[i] = !full[i] && !flush && (rst != RST_ENABLE);
      push[i]      = req_valid[i] && req_ready[i] &&
                     (req_waddr[i*REG_ADDR_W +: REG_ADDR_W] != '0);
      pop[i]       = grant && !flush && (gidx == RRW'(i));
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_fifo
    regfile_arb_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push[g]),
      .pop   (pop[g]),
      .din   ({req_waddr[g*REG_ADDR_W +: REG_ADDR_W], req_wdata[g*REG_W +: REG_W]}),
      .head  (head[g]),
      .full  (full[g]),
      .empty (empty[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= ZERO_WORD;
      rr       <= '0;
    end else if (flush) begin
      rf_we <= 1'b0;
    end else begin
      rf_we <= grant;
      if (grant) begin
        rf_waddr <= head[gidx].waddr;
        rf_wdata <= head[gidx].wdata;
        rr       <= RRW'((32'(gidx) + 1) % NREQ);
      end
    end
  end

  assign idle = (&empty) && !rf_we;

`ifdef REGFILE_ARB_SCOREBOARD_EN
  localparam int CW = $clog2(NREQ*FIFO_DEPTH+1) + 1;

  logic [CW-1:0] cnt     [REG_NUM];
  logic [CW-1:0] cnt_nxt [REG_NUM];

  // Several sources may accept the same register in one cycle, hence per-source increments.
  always_comb begin
    for (int unsigned r = 0; r < REG_NUM; r++) begin
      cnt_nxt[r] = cnt[r];
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (push[i] && (req_waddr[i*REG_ADDR_W +: REG_ADDR_W] == REG_ADDR_W'(r)))
          cnt_nxt[r] = cnt_nxt[r] + 1'b1;
      end
      if (rf_we && (rf_waddr == REG_ADDR_W'(r)))
        cnt_nxt[r] = cnt_nxt[r] - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned r = 0; r < REG_NUM; r++) begin
      if ((rst == RST_ENABLE) || flush) cnt[r] <= '0;
      else                              cnt[r] <= cnt_nxt[r];
    end
  end

  always_comb begin
    pending = '0;
    for (int unsigned r = 1; r < REG_NUM; r++) pending[r] = (cnt[r] != '0);
  end
`endif

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Bench for regfile_wport_arbiter: directed vector table, hand sequences, and random
// traffic checked against a queue-based reference model.
module tb_regfile_wport_arbiter;

  localparam int NREQ  = 2;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [1:0]  req_valid, req_ready;
  logic [9:0]  req_waddr;
  logic [63:0] req_wdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        idle;
`ifdef REGFILE_ARB_SCOREBOARD_EN
  logic [31:0] pending;
`endif

  always #5 clk = ~clk;

  regfile_wport_arbiter #(
    .NREQ       (NREQ),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_waddr (req_waddr),
    .req_wdata (req_wdata),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .idle      (idle)
`ifdef REGFILE_ARB_SCOREBOARD_EN
    , .pending (pending)
`endif
  );

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        mq [NREQ][$];
  int          m_rr;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          model_on;

  int checks;
  int errors;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] m_ready();
    logic [1:0] r;
    for (int i = 0; i < NREQ; i++) r[i] = (mq[i].size() < DEPTH) && !flush && !rst;
    return r;
  endfunction

  task automatic model_check();
    logic mi;
    mi = !m_we;
    for (int i = 0; i < NREQ; i++) if (mq[i].size() != 0) mi = 1'b0;
    chk("model_ready", 64'(req_ready), 64'(m_ready()));
    chk("model_rf_we", 64'(rf_we), 64'(m_we));
    if (m_we) begin
      chk("model_rf_waddr", 64'(rf_waddr), 64'(m_addr));
      chk("model_rf_wdata", 64'(rf_wdata), 64'(m_data));
    end
    chk("model_idle", 64'(idle), 64'(mi));
`ifdef REGFILE_ARB_SCOREBOARD_EN
    begin
      logic [31:0] pend;
      pend = '0;
      for (int i = 0; i < NREQ; i++)
        foreach (mq[i][k]) pend[mq[i][k].a] = 1'b1;
      if (m_we) pend[m_addr] = 1'b1;
      pend[0] = 1'b0;
      chk("model_pending", 64'(pending), 64'(pend));
    end
`endif
  endtask

  task automatic apply(input logic r, input logic f, input logic [1:0] v,
                       input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1);
    rst       = r;
    flush     = f;
    req_valid = v;
    req_waddr = {a1, a0};
    req_wdata = {d1, d0};
    #2;
    if (model_on) model_check();
  endtask

  task automatic step();
    logic [1:0] rdy;
    bit         found;
    int         g;
    ent_t       e;
    @(posedge clk);
    rdy = m_ready();
    if (rst) begin
      for (int i = 0; i < NREQ; i++) mq[i].delete();
      m_we = 1'b0; m_addr = '0; m_data = '0; m_rr = 0;
    end else if (flush) begin
      for (int i = 0; i < NREQ; i++) mq[i].delete();
      m_we = 1'b0;
    end else begin
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        g = (m_rr + k) % NREQ;
        if (!found && mq[g].size() > 0) begin
          found  = 1'b1;
          e      = mq[g].pop_front();
          m_addr = e.a;
          m_data = e.d;
          m_rr   = (g + 1) % NREQ;
        end
      end
      m_we = found;
      for (int i = 0; i < NREQ; i++)
        if (req_valid[i] && rdy[i] && req_waddr[i*5 +: 5] != 5'd0)
          mq[i].push_back({req_waddr[i*5 +: 5], req_wdata[i*32 +: 32]});
    end
    #1;
  endtask

  typedef struct {
    logic        r;
    logic [1:0]  v;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic [1:0]  e_rdy;
    logic        e_we;
    logic [4:0]  e_a;
    logic [31:0] e_d;
    logic        e_idle;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [1:0] v, logic [4:0] a0, logic [31:0] d0,
                              logic [4:0] a1, logic [31:0] d1, logic [1:0] e_rdy,
                              logic e_we, logic [4:0] e_a, logic [31:0] e_d, logic e_idle);
    vec_t t;
    t.r = r; t.v = v; t.a0 = a0; t.d0 = d0; t.a1 = a1; t.d1 = d1;
    t.e_rdy = e_rdy; t.e_we = e_we; t.e_a = e_a; t.e_d = e_d; t.e_idle = e_idle;
    return t;
  endfunction

  initial begin
    checks = 0; errors = 0; model_on = 1'b0;
    m_we = 1'b0; m_addr = '0; m_data = '0; m_rr = 0;

    // single source r5/r6 back-to-back
    tbl.push_back(mk(0, 2'b01, 5, 32'h11, 0, 0, 2'b11, 0, 0, 0, 1));
    tbl.push_back(mk(0, 2'b01, 6, 32'h22, 0, 0, 2'b11, 0, 0, 0, 0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'b11, 1, 5, 32'h11, 0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'b11, 1, 6, 32'h22, 0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'b11, 0, 0, 0, 1));
    // reset to put the rr pointer back at 0
    tbl.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1));
    // contention
    tbl.push_back(mk(0, 2'b11, 1, 32'hA0, 2, 32'hB0, 2'b11, 0, 0, 0, 1));
    tbl.push_back(mk(0, 2'b11, 3, 32'hA1, 4, 32'hB1, 2'b11, 0, 0, 0, 0));
    tbl.push_back(mk(0, 2'b11, 7, 32'hA2, 8, 32'hB2, 2'b01, 1, 1, 32'hA0, 0));
    tbl.push_back(mk(0, 2'b10, 0, 0, 8, 32'hB2, 2'b10, 1, 2, 32'hB0, 0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'b01, 1, 3, 32'hA1, 0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'b11, 1, 4, 32'hB1, 0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'b11, 1, 7, 32'hA2, 0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'b11, 1, 8, 32'hB2, 0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'b11, 0, 0, 0, 1));
    // r0 write accepted but dropped
    tbl.push_back(mk(0, 2'b10, 0, 0, 0, 32'hDEAD, 2'b11, 0, 0, 0, 1));
    tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'b11, 0, 0, 0, 1));
    tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'b11, 0, 0, 0, 1));

    // reset held 3 cycles with all requesters valid
    for (int c = 0; c < 3; c++) begin
      apply(1, 0, 2'b11, 5'd3, 32'h1, 5'd4, 32'h2);
      chk("reset_ready", 64'(req_ready), 64'd0);
      step();
      model_on = 1'b1;
    end
    apply(0, 0, 2'b00, 0, 0, 0, 0);
    chk("post_reset_we", 64'(rf_we), 64'd0);
    chk("post_reset_idle", 64'(idle), 64'd1);
    chk("post_reset_waddr", 64'(rf_waddr), 64'd0);
    chk("post_reset_wdata", 64'(rf_wdata), 64'd0);
`ifdef REGFILE_ARB_SCOREBOARD_EN
    chk("post_reset_pending", 64'(pending), 64'd0);
`endif
    step();

    foreach (tbl[n]) begin
      apply(tbl[n].r, 0, tbl[n].v, tbl[n].a0, tbl[n].d0, tbl[n].a1, tbl[n].d1);
      chk($sformatf("vec%0d_ready", n), 64'(req_ready), 64'(tbl[n].e_rdy));
      chk($sformatf("vec%0d_we", n), 64'(rf_we), 64'(tbl[n].e_we));
      if (tbl[n].e_we) begin
        chk($sformatf("vec%0d_waddr", n), 64'(rf_waddr), 64'(tbl[n].e_a));
        chk($sformatf("vec%0d_wdata", n), 64'(rf_wdata), 64'(tbl[n].e_d));
      end
      chk($sformatf("vec%0d_idle", n), 64'(idle), 64'(tbl[n].e_idle));
`ifdef REGFILE_ARB_SCOREBOARD_EN
      chk($sformatf("vec%0d_pending0", n), 64'(pending[0]), 64'd0);
`endif
      step();
    end

    // flush with three writes queued/in flight; flush-cycle pushes must be refused
    apply(0, 0, 2'b11, 5'd10, 32'h100, 5'd11, 32'h110);
    step();
    apply(0, 0, 2'b01, 5'd12, 32'h120, 0, 0);
    step();
    apply(0, 1, 2'b11, 5'd13, 32'h130, 5'd14, 32'h140);
    chk("flush_ready", 64'(req_ready), 64'd0);
    step();
    apply(0, 0, 2'b00, 0, 0, 0, 0);
    chk("flush_we", 64'(rf_we), 64'd0);
    chk("flush_idle", 64'(idle), 64'd1);
    step();
    for (int c = 0; c < 4; c++) begin
      apply(0, 0, 2'b00, 0, 0, 0, 0);
      chk($sformatf("post_flush_we%0d", c), 64'(rf_we), 64'd0);
      step();
    end

    // two queued writes to r9
    apply(0, 0, 2'b01, 5'd9, 32'h9A, 0, 0);
    step();
    apply(0, 0, 2'b01, 5'd9, 32'h9B, 0, 0);
`ifdef REGFILE_ARB_SCOREBOARD_EN
    chk("sb_pend9_a", 64'(pending[9]), 64'd1);
`endif
    step();
    apply(0, 0, 2'b00, 0, 0, 0, 0);
    chk("sb_first_data", 64'(rf_wdata), 64'h9A);
`ifdef REGFILE_ARB_SCOREBOARD_EN
    chk("sb_pend9_b", 64'(pending[9]), 64'd1);
`endif
    step();
    apply(0, 0, 2'b00, 0, 0, 0, 0);
    chk("sb_second_data", 64'(rf_wdata), 64'h9B);
`ifdef REGFILE_ARB_SCOREBOARD_EN
    chk("sb_pend9_c", 64'(pending[9]), 64'd1);
`endif
    step();
    apply(0, 0, 2'b00, 0, 0, 0, 0);
    chk("sb_done_we", 64'(rf_we), 64'd0);
`ifdef REGFILE_ARB_SCOREBOARD_EN
    chk("sb_pend9_d", 64'(pending[9]), 64'd0);
`endif
    step();

    // random traffic against the reference model
    for (int c = 0; c < 1500; c++) begin
      apply(($urandom_range(0, 199) == 0), ($urandom_range(0, 24) == 0), 2'($urandom),
            5'($urandom_range(0, 9)), $urandom, 5'($urandom_range(0, 9)), $urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
